register_dump_unit: RTL and testbench
=====================================

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

Interface
REQ-001 SHALL have parameter NBITS, default 32: register data width; a multiple of 8.
REQ-002 SHALL have parameter NREGS, default 32: number of registers dumped, indices 0..NREGS-1, max 32.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: dump request, sampled only in IDLE.
REQ-006 SHALL have port o_dbg_reg_sel, output, 5: register index driven to the register file debug select.
REQ-007 SHALL have port i_dbg_reg_data, input, NBITS: debug read data for o_dbg_reg_sel, valid in the cycle after the select changes.
REQ-008 SHALL have port o_tx_data, output, 8: byte offered to the serial transmitter.
REQ-009 SHALL have port o_tx_valid, output, 1: o_tx_data is valid.
REQ-010 SHALL have port i_tx_ready, input, 1: transmitter accepts the byte this cycle.
REQ-011 SHALL have port o_busy, output, 1: dump in progress.
REQ-012 SHALL have port o_done, output, 1: one-cycle pulse when the dump completes.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, LATCH, SEND, DONE.
REQ-014 IDLE: o_busy=0; i_start=1 -> SELECT, register index cleared to 0.
REQ-015 SELECT: o_dbg_reg_sel = index; o_busy=1 from this state through DONE inclusive; next state LATCH unconditionally.
REQ-016 LATCH: capture i_dbg_reg_data into an NBITS shift register; byte counter cleared to 0; next state SEND.
REQ-017 SEND: o_tx_valid=1; o_tx_data = shift register bits [NBITS-1:NBITS-8]; each register is sent MSB byte first.
REQ-018 A byte SHALL transfer only in a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-019 On a transfer: shift register shifts left 8; byte counter increments.
REQ-020 On the transfer of byte NBITS/8-1: if index = NREGS-1 -> DONE, else index+1 and -> SELECT.
REQ-021 DONE: o_done=1 for exactly one cycle, then -> IDLE.
REQ-022 o_tx_valid SHALL be 0 in every state other than SEND.
REQ-023 i_start SHALL be ignored outside IDLE; i_start held high SHALL start a new dump on the cycle after DONE.
REQ-024 Latency: from the i_start edge to the first o_tx_valid=1 SHALL be 3 cycles (SELECT, LATCH, SEND).
REQ-025 A full dump SHALL emit NREGS*NBITS/8 bytes (128 at defaults) with no byte repeated or skipped.
REQ-026 Per-register overhead with i_tx_ready tied high SHALL be 2 cycles (SELECT+LATCH); a default dump takes 32*(2+4)+1 = 193 cycles from the first SELECT to DONE inclusive.
REQ-027 o_dbg_reg_sel SHALL hold the current index in all states (0 in IDLE after reset).

Reset
REQ-028 When i_rst is asserted, without waiting for a clock edge: state=IDLE, index=0, byte counter=0, shift register=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, o_dbg_reg_sel=0.
REQ-029 Reset during SEND SHALL drop o_tx_valid immediately and abandon the dump; after release no dump resumes without a new i_start.
REQ-030 The first i_start sampled high after reset deassertion SHALL start a dump from register 0.

Verification
REQ-031 Registers loaded with value 0x0000_0100*k + k for k=0..31, i_tx_ready tied 1, pulse i_start -> 128 bytes; bytes 4..7 = 00 00 01 01; last 4 bytes = 00 00 1F 1F; o_done pulses at cycle 193; o_busy falls with it.
REQ-032 i_tx_ready toggles 1,0,0,1 repeatedly -> o_tx_data and o_tx_valid stable across stalled cycles; same 128-byte sequence as REQ-031.
REQ-033 i_start pulsed again at byte 50 of a dump -> ignored; exactly 128 bytes, one o_done.
REQ-034 i_rst asserted mid-cycle during byte 2 of register 7 -> o_tx_valid=0 and o_busy=0 before the next edge; after release, no output until i_start; new dump begins with register 0.
REQ-035 NREGS=4, NBITS=16 build -> 8 bytes, o_dbg_reg_sel walks 0..3, o_done after the last byte.
REQ-036 i_start held high continuously -> back-to-back dumps separated by one IDLE cycle, each 128 bytes.

Source files
------------

// File: rtl/register_dump_unit.sv
// Walks the register file debug port from index 0 to NREGS-1 and streams every
// register out as bytes, MSB byte first, over a valid/ready transmit port.
module register_dump_unit #(
  parameter int NBITS = 32,
  parameter int NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [4:0]       o_dbg_reg_sel,
  input  logic [NBITS-1:0] i_dbg_reg_data,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int         NBYTES    = NBITS / 8;
  localparam logic [7:0] BYTE_LAST = 8'(NBYTES - 1);
  localparam logic [4:0] IDX_LAST  = 5'(NREGS - 1);

  logic [2:0]       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [NBITS-1:0] shift_q, shift_d;

  // Transmit handshake: a byte moves on a rising edge where o_tx_valid and
  // i_tx_ready are both high; while valid is high and ready low, o_tx_data
  // holds because the shift register only advances on a transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SELECT;
          idx_d   = '0;
        end
      end
      SELECT: state_d = LATCH;
      LATCH: begin
        shift_d = i_dbg_reg_data;
        bcnt_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          shift_d = shift_q << 8;
          bcnt_d  = bcnt_q + 8'd1;
          if (bcnt_q == BYTE_LAST) begin
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = SELECT;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign o_dbg_reg_sel = idx_q;
  assign o_tx_data     = shift_q[NBITS-1 -: 8];
  assign o_tx_valid    = (state_q == SEND);
  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_register_dump_unit.sv
// Bench for register_dump_unit: register file model, byte scoreboard built
// from the register contents, plus a small NREGS=4/NBITS=16 instance.
module tb_register_dump_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        start = 1'b0;
  logic [4:0]  dbg_sel;
  logic [31:0] rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done;
  logic [2:0]  dbg_state;

  register_dump_unit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_dbg_reg_sel(dbg_sel), .i_dbg_reg_data(rdata),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
  );

  logic [31:0] regs [32];
  always @(posedge clk) rdata <= regs[dbg_sel];

  // ---------------- small instance ----------------
  logic        s_start = 1'b0;
  logic [4:0]  s_sel;
  logic [15:0] s_rdata = '0;
  logic [7:0]  s_tx_data;
  logic        s_valid, s_busy, s_done;
  logic [2:0]  s_state;

  register_dump_unit #(.NBITS(16), .NREGS(4)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(s_start),
    .o_dbg_reg_sel(s_sel), .i_dbg_reg_data(s_rdata),
    .o_tx_data(s_tx_data), .o_tx_valid(s_valid), .i_tx_ready(1'b1),
    .o_busy(s_busy), .o_done(s_done), .o_dbg_state(s_state)
  );

  logic [15:0] s_regs [4];
  always @(posedge clk) s_rdata <= s_regs[s_sel[1:0]];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  logic [7:0] s_rx[$];
  logic [4:0] s_sel_q[$];
  int n_done = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int rdy_mode = 0;
  int rdy_ph = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_dump();
    for (int k = 0; k < 32; k++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(regs[k][8*b +: 8]);
  endfunction

  // Monitor on the falling edge: a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid) check("valid_implies_busy", 32'(busy), 32'd1);
      if (tx_valid && tx_ready) begin
        rx.push_back(tx_data);
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done) n_done++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (s_valid) s_rx.push_back(s_tx_data);
      if (s_busy && (s_sel_q.size() == 0 || s_sel_q[$] != s_sel)) s_sel_q.push_back(s_sel);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = (rdy_ph == 0) || (rdy_ph == 3);
          rdy_ph = (rdy_ph + 1) % 4;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_dump(input bit chk_timing, input int pulse_at);
    int cyc, fv, d0;
    bit pulsed, got_done;
    cyc = 0; fv = -1; d0 = n_done; pulsed = 0; got_done = 0;
    rx.delete();
    push_dump();
    pulse_start();
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (tx_valid && fv < 0) fv = cyc;
      if (start) start = 1'b0;
      else if (pulse_at >= 0 && !pulsed && rx.size() >= pulse_at) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (done) begin got_done = 1; break; end
    end
    check("done_seen", 32'(got_done), 32'd1);
    if (chk_timing) begin
      check("first_valid_latency", 32'(fv), 32'd3);
      check("dump_cycles", 32'(cyc), 32'd193);
    end
    check("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("byte_count", 32'(rx.size()), 32'd128);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(n_done - d0), 32'd1);
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] exp_mid [4];
    logic [7:0] exp_end [4];
    int cnt, dn, since, cyc, sd;
    bit ok;
    exp_mid = '{8'h00, 8'h00, 8'h01, 8'h01};
    exp_end = '{8'h00, 8'h00, 8'h1F, 8'h1F};
    for (int k = 0; k < 32; k++) regs[k] = 32'h0000_0100 * 32'(k) + 32'(k);
    for (int k = 0; k < 4; k++) s_regs[k] = 16'($urandom);

    #3;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel", 32'(dbg_sel), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Known pattern, ready tied high
    rdy_mode = 0;
    run_dump(1, -1);
    for (int i = 0; i < 4; i++) begin
      check("byte4to7", 32'(rx[4+i]), 32'(exp_mid[i]));
      check("last4", 32'(rx[124+i]), 32'(exp_end[i]));
    end

    // Same pattern, ready 1,0,0,1 stall pattern
    rdy_mode = 1; rdy_ph = 0;
    run_dump(0, -1);
    for (int i = 0; i < 4; i++) check("stall_byte4to7", 32'(rx[4+i]), 32'(exp_mid[i]));
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // Random data, second start pulse mid-dump
    randomize_regs();
    run_dump(1, 50);
    repeat (3) @(negedge clk);
    check("no_restart_busy", 32'(busy), 32'd0);

    // Random data, random ready
    randomize_regs();
    rdy_mode = 2;
    run_dump(0, -1);
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // Asynchronous reset during byte 2 of register 7
    randomize_regs();
    rx.delete(); exp_q.delete();
    push_dump();
    pulse_start();
    cnt = 0;
    while (rx.size() != 30 && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("reach_byte30", 32'(rx.size()), 32'd30);
    #3;
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_sel", 32'(dbg_sel), 32'd7);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_sel", 32'(dbg_sel), 32'd0);
    check("async_rst_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); rx.delete();
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || busy || done) cnt++;
    end
    check("quiet_after_rst", 32'(cnt), 32'd0);
    run_dump(1, -1);

    // start held high: back-to-back dumps with one idle cycle between
    randomize_regs();
    rx.delete();
    push_dump(); push_dump();
    @(posedge clk); #1 start = 1'b1;
    dn = 0; since = -1; cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dn++;
        since = 0;
        if (dn == 2) begin start = 1'b0; break; end
      end else if (since >= 0 && dn == 1) begin
        since++;
        if (since == 1) check("gap_idle", 32'(busy), 32'd0);
        if (since == 2) check("gap_restart", 32'(busy), 32'd1);
      end
    end
    check("b2b_dones", 32'(dn), 32'd2);
    @(negedge clk); #1;
    check("b2b_bytes", 32'(rx.size()), 32'd256);
    check("b2b_exp_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("b2b_stopped", 32'(busy), 32'd0);

    // Small build: 4 registers of 16 bits
    s_rx.delete(); s_sel_q.delete();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    cyc = 0; ok = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_done) begin ok = 1; break; end
    end
    check("small_done", 32'(ok), 32'd1);
    check("small_cycles", 32'(cyc), 32'd17);
    check("small_bytes_at_done", 32'(s_rx.size()), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("small_hi", 32'(s_rx[2*k]), 32'(s_regs[k][15:8]));
      check("small_lo", 32'(s_rx[2*k+1]), 32'(s_regs[k][7:0]));
    end
    check("small_sel_count", 32'(s_sel_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      sd = (k < s_sel_q.size()) ? int'(s_sel_q[k]) : -1;
      check("small_sel_walk", 32'(sd), 32'(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
